// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for param_cpu_core and its ALU.
// Contents: opcode and ALU-op encodings, FSM state type, instruction field helpers.
// Latency/backpressure: n/a (declarations only).
package cpu_pkg;

  // Upper-half opcodes (ir[15]=1). ir[15]=0 selects an ALU operation.
  localparam logic [3:0] OP_MVI = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JC  = 4'hD;
  localparam logic [3:0] OP_NOP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU operation codes carried in ir[14:12]
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_NOTA = 3'd5;
  localparam logic [2:0] ALU_NOTB = 3'd6;
  localparam logic [2:0] ALU_GT   = 3'd7;

  // Instruction field positions (LSB of each field)
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    MEM,
    HALT
  } state_t;

  function automatic logic [3:0] f_op(input logic [15:0] ir);
    return ir[OP_LSB +: 4];
  endfunction

  function automatic logic [2:0] f_alu(input logic [15:0] ir);
    return ir[OP_LSB +: 3];
  endfunction

  function automatic logic [2:0] f_rd(input logic [15:0] ir);
    return ir[RD_LSB +: 3];
  endfunction

  function automatic logic [2:0] f_rs1(input logic [15:0] ir);
    return ir[RS1_LSB +: 3];
  endfunction

  function automatic logic [2:0] f_rs2(input logic [15:0] ir);
    return ir[RS2_LSB +: 3];
  endfunction

  function automatic logic [7:0] f_imm8(input logic [15:0] ir);
    return ir[IMM_LSB +: 8];
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational DATA_W-bit ALU with carry/borrow and zero flags.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: a, b operands; op ALU code; result, carry (add carry-out / sub borrow), zero.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      ALU_SUB: begin
        result = a - b;
        carry  = (a < b);  // borrow
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOTA: result = ~a;
      ALU_NOTB: result = ~b;
      ALU_GT:   result = (a > b) ? DATA_W'(1) : '0;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/param_cpu_core.sv
// param_cpu_core: multi-cycle 16-bit-instruction, 8-register core with loadable imem and dmem.
// Latency: 2 cycles per instruction (FETCH, EXEC), 3 for LD (extra MEM cycle).
// Backpressure: none; start and prog_we are ignored unless the core is IDLE or HALT.
// Ports: clk/reset (async, active-high); start; prog_we/prog_addr/prog_data imem load;
//        dbg_addr/dbg_data combinational register peek; pc, busy, halted, carry, zero, retire status.
module param_cpu_core
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 256,
  localparam int PC_W      = $clog2(IMEM_DEPTH),
  localparam int DA_W      = $clog2(DMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_we,
  input  logic [PC_W-1:0]   prog_addr,
  input  logic [15:0]       prog_data,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              halted,
  output logic              carry,
  output logic              zero,
  output logic              retire
);

  state_t state;
  state_t next_state;

  logic [15:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] regs [8];

  logic [15:0]       ir;
  logic [DATA_W-1:0] mem_rdata;

  logic [3:0]        op;
  logic [2:0]        rd;
  logic [7:0]        imm8;
  logic [DA_W-1:0]   daddr;
  logic [PC_W-1:0]   target;
  logic              stopped;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              alu_zero;

  assign op     = f_op(ir);
  assign rd     = f_rd(ir);
  assign imm8   = f_imm8(ir);
  assign daddr  = imm8[DA_W-1:0];
  assign target = imm8[PC_W-1:0];

  assign stopped  = (state == IDLE) || (state == HALT);
  assign busy     = (state == FETCH) || (state == EXEC) || (state == MEM);
  assign halted   = (state == HALT);
  // LD completes in MEM, every other instruction (HLT included) in EXEC
  assign retire   = ((state == EXEC) && (op != OP_LD)) || (state == MEM);
  assign dbg_data = regs[dbg_addr];

  cpu_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a      (regs[f_rs1(ir)]),
    .b      (regs[f_rs2(ir)]),
    .op     (f_alu(ir)),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  // Instruction memory: host-loaded only while stopped, never reset.
  // A write coinciding with start lands before the first FETCH reads it.
  always_ff @(posedge clk) begin
    if (prog_we && stopped) begin
      imem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, HALT: begin
        if (start) next_state = FETCH;
      end
      FETCH: next_state = EXEC;
      EXEC: begin
        if (op == OP_LD)       next_state = MEM;
        else if (op == OP_HLT) next_state = HALT;
        else                   next_state = FETCH;
      end
      MEM:     next_state = FETCH;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: pc, ir, flags, register file and data memory
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      ir        <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      mem_rdata <= '0;
      regs      <= '{default: '0};
      dmem      <= '{default: '0};
    end else begin
      case (state)
        IDLE, HALT: begin
          if (start) pc <= '0;
        end
        FETCH: begin
          ir <= imem[pc];
          pc <= pc + PC_W'(1);  // power-of-2 depth: natural wrap
        end
        EXEC: begin
          if (!op[3]) begin
            // ALU sources are read combinationally before this write lands
            regs[rd] <= alu_result;
            carry    <= alu_carry;
            zero     <= alu_zero;
          end else begin
            case (op)
              OP_MVI: regs[rd] <= DATA_W'(imm8);
              OP_LD:  mem_rdata <= dmem[daddr];
              OP_ST:  dmem[daddr] <= regs[rd];
              OP_JMP: pc <= target;
              OP_JZ:  if (zero)  pc <= target;
              OP_JC:  if (carry) pc <= target;
              OP_NOP, OP_HLT: ;
              default: ;
            endcase
          end
        end
        MEM: regs[rd] <= mem_rdata;
        default: ;
      endcase
    end
  end

endmodule
